// File: rtl/p2s_pkg.sv
// Shared definitions for the parallel-to-serial transmitter: FSM state
// encoding, default frame geometry and the counter-width helper.
package p2s_pkg;

   localparam int DEF_WIDTH      = 4;
   localparam int DEF_GAP_CYCLES = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   // Width of a down/up counter that must hold values 0..n-1; never below
   // one bit so a single-cycle gap still has a legal (constant zero) counter.
   function automatic int cntWidth(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/parallel2serial_tx_if.sv
// Bundle of the transmitter's word handshake and serial output signals.
// The slave modport is the transmitter's view, master is the feeder/receiver side.
interface parallel2serial_tx_if
   import p2s_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             sd;
   logic             sl;
   logic             frame_done;
   logic             busy;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  sd,
      input  sl,
      input  frame_done,
      input  busy
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output sd,
      output sl,
      output frame_done,
      output busy
   );

endinterface

// File: rtl/p2s_hold_buf.sv
// One-entry holding register on the valid/ready input. A pop frees the entry
// on the same edge, so a new word may be accepted in that cycle without a bubble.
module p2s_hold_buf
   import p2s_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             pop_i,
   output logic             hold_full_o,
   output logic [WIDTH-1:0] hold_data_o
);

   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             push;

   assign in_ready_o  = !full_q || pop_i;
   assign push        = in_valid_i && in_ready_o;
   assign hold_full_o = full_q;
   assign hold_data_o = data_q;

   // Next entry contents: a push wins over a pop since it refills the slot
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (push) begin
         full_d = 1'b1;
         data_d = in_data_i;
      end else if (pop_i) begin
         full_d = 1'b0;
      end
   end

   // Entry register, emptied immediately by reset
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/parallel2serial_tx.sv
// Parallel-to-serial feeder for the 4-bit serial receiver. Words are shifted
// out LSB-first with sl high for each bit, then sl drops for GAP_CYCLES so the
// receiver can transfer its shift register.
module parallel2serial_tx
   import p2s_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
   input logic                  clk,
   input logic                  rst_,
   parallel2serial_tx_if.slave  bus
);

   localparam int BCW = cntWidth(WIDTH);
   localparam int GCW = cntWidth(GAP_CYCLES);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
   localparam logic [GCW-1:0] GAP_LOAD = GCW'(GAP_CYCLES - 1);

   if (WIDTH < 2) begin : gBadWidth
      $error("parallel2serial_tx: WIDTH must be >= 2");
   end
   if (GAP_CYCLES < 1) begin : gBadGap
      $error("parallel2serial_tx: GAP_CYCLES must be >= 1");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BCW-1:0]   bitCnt_q, bitCnt_d;
   logic [GCW-1:0]   gapCnt_q, gapCnt_d;
   logic             loadNow;
   logic             holdFull;
   logic [WIDTH-1:0] holdData;
   logic             sdComb, slComb, frameDoneComb;

   p2s_hold_buf #(.WIDTH(WIDTH)) uHold (
      .clk         (clk),
      .rst_        (rst_),
      .in_data_i   (bus.in_data),
      .in_valid_i  (bus.in_valid),
      .in_ready_o  (bus.in_ready),
      .pop_i       (loadNow),
      .hold_full_o (holdFull),
      .hold_data_o (holdData)
   );

   // Frame sequencing: shift WIDTH bits, hold the strobe low for the gap,
   // then reload from the hold register straight away if a word is waiting
   always_comb begin
      state_d       = state_q;
      shreg_d       = shreg_q;
      bitCnt_d      = bitCnt_q;
      gapCnt_d      = gapCnt_q;
      loadNow       = 1'b0;
      sdComb        = 1'b0;
      slComb        = 1'b0;
      frameDoneComb = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (holdFull) begin
               loadNow = 1'b1;
            end
         end
         ST_SHIFT: begin
            slComb   = 1'b1;
            sdComb   = shreg_q[0];
            shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
            bitCnt_d = bitCnt_q + BCW'(1);
            if (bitCnt_q == LAST_BIT) begin
               state_d  = ST_GAP;
               bitCnt_d = '0;
               gapCnt_d = GAP_LOAD;
            end
         end
         ST_GAP: begin
            frameDoneComb = (gapCnt_q == GAP_LOAD);
            if (gapCnt_q == '0) begin
               if (holdFull) begin
                  loadNow = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               gapCnt_d = gapCnt_q - GCW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (loadNow) begin
         state_d  = ST_SHIFT;
         shreg_d  = holdData;
         bitCnt_d = '0;
      end
   end

   // State, shift register and counters; reset abandons any frame at once
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q  <= ST_IDLE;
         shreg_q  <= '0;
         bitCnt_q <= '0;
         gapCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitCnt_q <= bitCnt_d;
         gapCnt_q <= gapCnt_d;
      end
   end

   assign bus.sd         = sdComb;
   assign bus.sl         = slComb;
   assign bus.frame_done = frameDoneComb;
   assign bus.busy       = (state_q != ST_IDLE) || holdFull;

endmodule

// File: tb/tb_parallel2serial_tx.sv
// Bench for parallel2serial_tx: two instances (4-bit/gap 1 and 8-bit/gap 3)
// driven with directed and random words. A receiver-style monitor rebuilds
// each frame and compares it with a scoreboard of expected words and start cycles.
module tb_parallel2serial_tx;

   localparam int WA = 4;
   localparam int GA = 1;
   localparam int WB = 8;
   localparam int GB = 3;

   typedef struct {
      logic [7:0] word;
      int         startCyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_ = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] inData[2];
   logic       inValid[2];
   logic       inReadyS[2];
   logic       sdS[2];
   logic       slS[2];
   logic       doneS[2];
   logic       busyS[2];

   exp_t q0[$];
   exp_t q1[$];
   int   nextFree[2];
   int   stalls[2];

   bit         inFrame[2];
   bit         prevSl[2];
   int         bitCnt[2];
   logic [7:0] got[2];
   exp_t       cur[2];

   parallel2serial_tx_if #(.WIDTH(WA)) busA ();
   parallel2serial_tx_if #(.WIDTH(WB)) busB ();

   parallel2serial_tx #(.WIDTH(WA), .GAP_CYCLES(GA)) dutA (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (busA)
   );

   parallel2serial_tx #(.WIDTH(WB), .GAP_CYCLES(GB)) dutB (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (busB)
   );

   assign busA.in_data  = inData[0][WA-1:0];
   assign busA.in_valid = inValid[0];
   assign busB.in_data  = inData[1];
   assign busB.in_valid = inValid[1];

   assign inReadyS[0] = busA.in_ready;
   assign sdS[0]      = busA.sd;
   assign slS[0]      = busA.sl;
   assign doneS[0]    = busA.frame_done;
   assign busyS[0]    = busA.busy;
   assign inReadyS[1] = busB.in_ready;
   assign sdS[1]      = busB.sd;
   assign slS[1]      = busB.sl;
   assign doneS[1]    = busB.frame_done;
   assign busyS[1]    = busB.busy;

   always #5 clk = ~clk;

   // Edge counter used to timestamp accepts and frame starts
   always @(posedge clk) cyc++;

   function automatic int widthOf(input int d);
      return (d == 0) ? WA : WB;
   endfunction

   function automatic int gapOf(input int d);
      return (d == 0) ? GA : GB;
   endfunction

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference timing: first bit appears the cycle after the edge following
   // the accept, but never before the previous frame plus its gap has ended.
   task automatic pushExp(input int d, input logic [7:0] w, input int acceptEdge);
      exp_t e;
      int   s;
      s = (acceptEdge + 1 > nextFree[d]) ? acceptEdge + 1 : nextFree[d];
      nextFree[d] = s + widthOf(d) + gapOf(d);
      e.word = w;
      e.startCyc = s;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic popExp(input int d, output exp_t e, output bit ok);
      ok = 1'b0;
      e.word = '0;
      e.startCyc = 0;
      if (d == 0 && q0.size() > 0) begin
         e = q0.pop_front();
         ok = 1'b1;
      end else if (d == 1 && q1.size() > 0) begin
         e = q1.pop_front();
         ok = 1'b1;
      end
   endtask

   task automatic assertReset();
      rst_ = 1'b0;
      q0.delete();
      q1.delete();
      nextFree[0] = 0;
      nextFree[1] = 0;
   endtask

   task automatic releaseReset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_ = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         checkOutput("resetInReady", inReadyS[d], 1);
         checkOutput("resetSd", sdS[d], 0);
         checkOutput("resetSl", slS[d], 0);
         checkOutput("resetDone", doneS[d], 0);
         checkOutput("resetBusy", busyS[d], 0);
      end
   endtask

   // Present one word and hold it until the DUT takes it
   task automatic applyStimulus(input int d, input logic [7:0] w);
      bit accepted;
      accepted = 1'b0;
      @(negedge clk);
      inData[d] = w;
      inValid[d] = 1'b1;
      for (int k = 0; k < 100 && !accepted; k++) begin
         #1;
         if (inReadyS[d]) begin
            pushExp(d, w, cyc + 1);
            accepted = 1'b1;
            @(posedge clk);
         end else begin
            stalls[d]++;
            @(negedge clk);
         end
      end
      if (!accepted) begin
         checkOutput("acceptTimeout", 0, 1);
         inValid[d] = 1'b0;
      end
   endtask

   task automatic idleCycles(input int d, input int n);
      @(negedge clk);
      inValid[d] = 1'b0;
      for (int k = 1; k < n; k++) @(negedge clk);
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk);
         done = (q0.size() == 0) && (q1.size() == 0) && !inFrame[0] && !inFrame[1]
                && !busyS[0] && !busyS[1];
      end
      checkOutput("drained", done, 1);
   endtask

   // Receiver model: samples mid-cycle, rebuilds each frame LSB-first and
   // checks start time, length, contents and the frame_done pulse.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_) begin
            checkOutput("resetHoldSl", slS[d], 0);
            checkOutput("resetHoldDone", doneS[d], 0);
            inFrame[d] = 1'b0;
            prevSl[d] = 1'b0;
            bitCnt[d] = 0;
         end else begin
            bit fell;
            bit ok;
            fell = prevSl[d] && !slS[d];
            checkOutput("frameDone", doneS[d], fell);
            if (!slS[d]) checkOutput("sdIdle", sdS[d], 0);
            if (slS[d] && !prevSl[d]) begin
               popExp(d, cur[d], ok);
               if (!ok) begin
                  checkOutput("unexpectedFrame", 1, 0);
               end else begin
                  checkOutput("frameStart", cyc, cur[d].startCyc);
               end
               inFrame[d] = ok;
               bitCnt[d] = 0;
               got[d] = '0;
            end
            if (slS[d]) begin
               if (bitCnt[d] < 8) got[d][bitCnt[d]] = sdS[d];
               bitCnt[d]++;
            end
            if (fell && inFrame[d]) begin
               checkOutput("frameLen", bitCnt[d], widthOf(d));
               checkOutput("frameData", got[d], cur[d].word);
               inFrame[d] = 1'b0;
            end
            prevSl[d] = slS[d];
         end
      end
   end

   initial begin
      logic [7:0] w;
      inData[0] = '0;
      inData[1] = '0;
      inValid[0] = 1'b0;
      inValid[1] = 1'b0;
      stalls[0] = 0;
      stalls[1] = 0;

      $display("[TB] reset");
      assertReset();
      releaseReset();

      $display("[TB] single word 1011");
      applyStimulus(0, 8'h0B);
      idleCycles(0, 1);
      drain();

      $display("[TB] back-to-back A then 5");
      applyStimulus(0, 8'h0A);
      applyStimulus(0, 8'h05);
      idleCycles(0, 1);
      drain();

      $display("[TB] backpressure with three words");
      stalls[0] = 0;
      applyStimulus(0, 8'h01);
      applyStimulus(0, 8'h0E);
      applyStimulus(0, 8'h07);
      idleCycles(0, 1);
      checkOutput("backpressure", (stalls[0] > 0), 1);
      drain();

      $display("[TB] reset in the middle of a frame");
      applyStimulus(0, 8'h0C);
      idleCycles(0, 1);
      repeat (3) @(posedge clk);
      #2;
      assertReset();
      #1;
      checkOutput("asyncSl", slS[0], 0);
      checkOutput("asyncSd", sdS[0], 0);
      checkOutput("asyncDone", doneS[0], 0);
      checkOutput("asyncBusy", busyS[0], 0);
      releaseReset();
      applyStimulus(0, 8'h03);
      idleCycles(0, 1);
      drain();

      $display("[TB] wide instance, word 96");
      applyStimulus(1, 8'h96);
      idleCycles(1, 1);
      drain();

      $display("[TB] random traffic");
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 25; i++) begin
            w = 8'($urandom);
            if (d == 0) w = w & 8'h0F;
            applyStimulus(d, w);
            if ($urandom_range(0, 3) != 0) idleCycles(d, $urandom_range(1, 6));
         end
         idleCycles(d, 1);
         drain();
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
